// File: rtl/cic_pkg.sv
// Shared CIC definitions: width helpers and the rate word type used by the
// interpolator and the decimator.
package cic_pkg;

  localparam int RATE_W = 16;

  typedef logic [RATE_W-1:0] rate_t;

  function automatic int clog2_l(input longint unsigned v);
    int res;
    res = 0;
    for (int i = 63; i >= 0; i--) begin
      if ((64'd1 << i) >= v) res = i;
    end
    return res;
  endfunction

  // Full-precision register width for an N-stage CIC with ratio R and delay M.
  function automatic int b_max(input int n, input int r, input int m, input int inp_dw);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * longint'(r * m);
    return inp_dw + clog2_l(p);
  endfunction

  // Input width of comb stage j; its output is one bit wider.
  function automatic int comb_w(input int j, input int inp_dw);
    return inp_dw + j;
  endfunction

endpackage

// File: rtl/upsampler_variable.sv
// Input handshake pacing, pending/active rate tracking and zero-stuffing
// for the variable-rate CIC interpolator.
module upsampler_variable
  import cic_pkg::*;
#(
  parameter int IN_W    = 19,
  parameter int OUT_W   = 22,
  parameter int RATE_DW = 16,
  parameter int CIC_R   = 4,
  parameter int CIC_N   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [RATE_DW-1:0] rate_tdata,
  input  logic               rate_tvalid,
  input  logic               in_tvalid,
  output logic               in_tready,
  output logic               in_xfer,
  input  logic [IN_W-1:0]    comb_tdata,
  input  logic               comb_tvalid,
  output logic [OUT_W-1:0]   up_tdata,
  output logic               up_tvalid
);

  localparam logic [RATE_DW-1:0] R_MAX = RATE_DW'(CIC_R);
  localparam logic [RATE_DW-1:0] R_ONE = RATE_DW'(1);

  logic [RATE_DW-1:0]      cnt_q, cnt_d;
  logic [RATE_DW-1:0]      pend_q, pend_d;
  logic [RATE_DW-1:0]      stuff_q, stuff_d;
  logic [RATE_DW-1:0]      act_q [CIC_N];
  logic [RATE_DW-1:0]      act_d [CIC_N];
  logic signed [OUT_W-1:0] up_data_q, up_data_d;
  logic                    up_vld_q, up_vld_d;
  logic [RATE_DW-1:0]      r_eff;
  logic                    rate_ok;

  assign rate_ok   = rate_tvalid && (rate_tdata != '0) && (rate_tdata <= R_MAX);
  assign r_eff     = rate_ok ? rate_tdata : pend_q;
  assign in_tready = reset_n && (cnt_q == '0);
  assign in_xfer   = in_tvalid && in_tready;

  // act_q carries the rate seen at each cycle through a CIC_N-deep line so the
  // comb output is stuffed with the rate that was active when it was accepted.
  always_comb begin
    pend_d = r_eff;
    cnt_d  = cnt_q;
    if (in_xfer)              cnt_d = r_eff - R_ONE;
    else if (cnt_q != '0)     cnt_d = cnt_q - R_ONE;
    act_d[0] = r_eff;
    for (int k = 1; k < CIC_N; k++) act_d[k] = act_q[k-1];
    up_data_d = '0;
    up_vld_d  = 1'b0;
    stuff_d   = stuff_q;
    if (comb_tvalid) begin
      up_data_d = OUT_W'($signed(comb_tdata));
      up_vld_d  = 1'b1;
      stuff_d   = act_q[CIC_N-1] - R_ONE;
    end else if (stuff_q != '0) begin
      up_vld_d  = 1'b1;
      stuff_d   = stuff_q - R_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pend_q    <= R_MAX;
      stuff_q   <= '0;
      up_data_q <= '0;
      up_vld_q  <= 1'b0;
      for (int k = 0; k < CIC_N; k++) act_q[k] <= R_MAX;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      stuff_q   <= stuff_d;
      up_data_q <= up_data_d;
      up_vld_q  <= up_vld_d;
      for (int k = 0; k < CIC_N; k++) act_q[k] <= act_d[k];
    end
  end

  assign up_tdata  = up_data_q;
  assign up_tvalid = up_vld_q;

endmodule

// File: rtl/cic_i.sv
// Variable-rate CIC interpolator: combs at the input rate, zero-stuffing by r,
// integrators at the clock rate, truncated registered output.
module cic_i
  import cic_pkg::*;
#(
  parameter int INP_DW  = 16,
  parameter int OUT_DW  = 22,
  parameter int RATE_DW = 16,
  parameter int CIC_R   = 4,
  parameter int CIC_N   = 3,
  parameter int CIC_M   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INP_DW-1:0]  s_axis_in_tdata,
  input  logic               s_axis_in_tvalid,
  output logic               s_axis_in_tready,
  input  logic [RATE_DW-1:0] s_axis_rate_tdata,
  input  logic               s_axis_rate_tvalid,
  output logic [OUT_DW-1:0]  m_axis_out_tdata,
  output logic               m_axis_out_tvalid
);

  localparam int B_MAX   = b_max(CIC_N, CIC_R, CIC_M, INP_DW);
  localparam int C_OUT_W = comb_w(CIC_N, INP_DW);

  function automatic logic [OUT_DW-1:0] trunc_out(input logic [B_MAX-1:0] v);
    return v[B_MAX-1 -: OUT_DW];
  endfunction

  logic                    xfer;
  logic signed [B_MAX-1:0] up_data;
  logic                    up_vld;
  logic [OUT_DW-1:0]       out_data_q, out_data_d;
  logic                    out_vld_q, out_vld_d;

  // Comb stages: advance only on their input strobe, full precision.
  for (genvar j = 0; j < CIC_N; j++) begin : g_comb
    localparam int W = comb_w(j, INP_DW);
    logic signed [W-1:0] x;
    logic                stb;
    logic signed [W-1:0] dly_q [CIC_M];
    logic signed [W-1:0] dly_d [CIC_M];
    logic signed [W:0]   y_q, y_d;
    logic                vld_q, vld_d;

    if (j == 0) begin : g_src
      assign x   = s_axis_in_tdata;
      assign stb = xfer;
    end else begin : g_src
      assign x   = g_comb[j-1].y_q;
      assign stb = g_comb[j-1].vld_q;
    end

    always_comb begin
      dly_d = dly_q;
      y_d   = y_q;
      vld_d = stb;
      if (stb) begin
        y_d      = {x[W-1], x} - {dly_q[CIC_M-1][W-1], dly_q[CIC_M-1]};
        dly_d[0] = x;
        for (int k = 1; k < CIC_M; k++) dly_d[k] = dly_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        y_q   <= '0;
        vld_q <= 1'b0;
        for (int k = 0; k < CIC_M; k++) dly_q[k] <= '0;
      end else begin
        y_q   <= y_d;
        vld_q <= vld_d;
        for (int k = 0; k < CIC_M; k++) dly_q[k] <= dly_d[k];
      end
    end
  end

  // Upsampler stage
  upsampler_variable #(
    .IN_W    (C_OUT_W),
    .OUT_W   (B_MAX),
    .RATE_DW (RATE_DW),
    .CIC_R   (CIC_R),
    .CIC_N   (CIC_N)
  ) u_up (
    .clk         (clk),
    .reset_n     (reset_n),
    .rate_tdata  (s_axis_rate_tdata),
    .rate_tvalid (s_axis_rate_tvalid),
    .in_tvalid   (s_axis_in_tvalid),
    .in_tready   (s_axis_in_tready),
    .in_xfer     (xfer),
    .comb_tdata  (g_comb[CIC_N-1].y_q),
    .comb_tvalid (g_comb[CIC_N-1].vld_q),
    .up_tdata    (up_data),
    .up_tvalid   (up_vld)
  );

  // Integrator stages: wrap modulo 2^B_MAX, hold while the strobe is low.
  for (genvar k = 0; k < CIC_N; k++) begin : g_int
    logic signed [B_MAX-1:0] x;
    logic                    stb;
    logic signed [B_MAX-1:0] acc_q, acc_d;
    logic                    vld_q, vld_d;

    if (k == 0) begin : g_src
      assign x   = up_data;
      assign stb = up_vld;
    end else begin : g_src
      assign x   = g_int[k-1].acc_q;
      assign stb = g_int[k-1].vld_q;
    end

    always_comb begin
      acc_d = acc_q;
      if (stb) acc_d = acc_q + x;
      vld_d = stb;
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        acc_q <= '0;
        vld_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        vld_q <= vld_d;
      end
    end
  end

  // Output register stage
  always_comb begin
    out_vld_d  = g_int[CIC_N-1].vld_q;
    out_data_d = out_data_q;
    if (g_int[CIC_N-1].vld_q) out_data_d = trunc_out(g_int[CIC_N-1].acc_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign m_axis_out_tdata  = out_data_q;
  assign m_axis_out_tvalid = out_vld_q;

endmodule

// File: tb/tb_cic_i.sv
// Directed bench for cic_i at default parameters (B_max = 22, no truncation).
module tb_cic_i;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_tdata = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic [15:0] rate_tdata = '0;
  logic        rate_tvalid = 1'b0;
  logic [21:0] out_tdata;
  logic        out_tvalid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cic_i #(
    .INP_DW(16), .OUT_DW(22), .RATE_DW(16), .CIC_R(4), .CIC_N(3), .CIC_M(1)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .s_axis_in_tdata    (in_tdata),
    .s_axis_in_tvalid   (in_tvalid),
    .s_axis_in_tready   (in_tready),
    .s_axis_rate_tdata  (rate_tdata),
    .s_axis_rate_tvalid (rate_tvalid),
    .m_axis_out_tdata   (out_tdata),
    .m_axis_out_tvalid  (out_tvalid)
  );

  typedef struct {
    logic [15:0] din;
    logic        dv;
    logic        exp_rdy;
    logic        exp_vld;
    int          exp_dat;
  } vec_t;

  vec_t imp_tbl [24];
  int   h_imp [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic v,
                       input logic [15:0] rd, input logic rv);
    @(negedge clk);
    reset_n     = 1'b1;
    in_tdata    = d;
    in_tvalid   = v;
    rate_tdata  = rd;
    rate_tvalid = rv;
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n     = 1'b0;
      in_tdata    = '0;
      in_tvalid   = 1'b0;
      rate_tdata  = '0;
      rate_tvalid = 1'b0;
      #1;
      chk("rst_tready", 32'(in_tready), 0);
      if (i > 0) begin
        chk("rst_tvalid", 32'(out_tvalid), 0);
        chk("rst_tdata", 32'($signed(out_tdata)), 0);
      end
    end
  endtask

  task automatic run_impulse(input int n);
    for (int c = 0; c < n; c++) begin
      drive(imp_tbl[c].din, imp_tbl[c].dv, 16'd0, 1'b0);
      chk($sformatf("imp_rdy[%0d]", c), 32'(in_tready), 32'(imp_tbl[c].exp_rdy));
      chk($sformatf("imp_vld[%0d]", c), 32'(out_tvalid), 32'(imp_tbl[c].exp_vld));
      chk($sformatf("imp_dat[%0d]", c), 32'($signed(out_tdata)), imp_tbl[c].exp_dat);
    end
  endtask

  // DC 100 for 40 cycles; optional rate strobes on cycles 0 and 1.
  task automatic run_dc(input string tag, input logic [15:0] rd0, input logic rv0,
                        input logic [15:0] rd1, input logic rv1,
                        input int per, input int steady);
    for (int c = 0; c < 40; c++) begin
      drive(16'd100, 1'b1, (c == 0) ? rd0 : rd1,
            (c == 0) ? rv0 : ((c == 1) ? rv1 : 1'b0));
      chk($sformatf("%s_rdy[%0d]", tag, c), 32'(in_tready), 32'((c % per) == 0));
      if (c >= 24) begin
        chk($sformatf("%s_vld[%0d]", tag, c), 32'(out_tvalid), 1);
        chk($sformatf("%s_dat[%0d]", tag, c), 32'($signed(out_tdata)), steady);
      end
    end
  endtask

  initial begin
    int nv_a, nv_b;

    for (int c = 0; c < 24; c++) begin
      imp_tbl[c].din     = (c == 0) ? 16'd1 : 16'd0;
      imp_tbl[c].dv      = 1'b1;
      imp_tbl[c].exp_rdy = ((c % 4) == 0);
      imp_tbl[c].exp_vld = (c >= 8);
      imp_tbl[c].exp_dat = (c >= 8 && c < 18) ? h_imp[c-8] : 0;
    end

    do_reset(2);
    run_impulse(24);

    do_reset(2);
    run_dc("dc_r4", 16'd0, 1'b0, 16'd0, 1'b0, 4, 1600);

    // Rate update applied on the same cycle as the first transfer.
    do_reset(2);
    run_dc("dc_r2", 16'd2, 1'b1, 16'd0, 1'b0, 2, 400);

    do_reset(2);
    run_dc("dc_inval", 16'd0, 1'b1, 16'd5, 1'b1, 4, 1600);

    do_reset(2);
    run_dc("dc_r1", 16'd1, 1'b1, 16'd0, 1'b0, 1, 100);

    // Isolated bursts: rate change to 2 lands mid-burst of an r=4 sample.
    do_reset(2);
    nv_a = 0;
    nv_b = 0;
    for (int c = 0; c < 32; c++) begin
      drive(16'd7, (c == 0 || c == 16), 16'd2, (c == 1));
      if (c == 1 || c == 2 || c == 3 || c == 17)
        chk($sformatf("rc_rdy[%0d]", c), 32'(in_tready), 0);
      if (c == 4 || c == 16 || c == 18)
        chk($sformatf("rc_rdy[%0d]", c), 32'(in_tready), 1);
      if (out_tvalid === 1'b1) begin
        if (c < 16) nv_a++;
        else        nv_b++;
      end
    end
    chk("rc_burst_r4_valids", nv_a, 4);
    chk("rc_burst_r2_valids", nv_b, 2);

    // Reset in the middle of an impulse burst, then a clean impulse.
    do_reset(2);
    run_impulse(10);
    do_reset(1);
    drive(16'd0, 1'b0, 16'd0, 1'b0);
    chk("mid_rst_vld", 32'(out_tvalid), 0);
    chk("mid_rst_dat", 32'($signed(out_tdata)), 0);
    chk("mid_rst_rdy", 32'(in_tready), 1);
    for (int c = 0; c < 12; c++) begin
      drive(16'd0, 1'b0, 16'd0, 1'b0);
      chk($sformatf("mid_rst_quiet[%0d]", c), 32'(out_tvalid), 0);
    end
    run_impulse(24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
